adc_trig_gate: RTL and testbench
================================

# adc_trig_gate

Trigger and capture-length gate for one RF-ADC channel. It sits in the rf_clk domain between the RF-ADC AXI-stream output and one `s_axis` lane of `adc_data_path`. After being armed, it waits for a trigger condition on the incoming samples and forwards exactly `cap_beats` 128-bit beats, marking the final beat with tlast. All other ADC data is discarded, so the downstream datamover only sees the requested window.

## Interface
- `DATA_WIDTH`, 128: stream beat width. Must be an integer multiple of `SAMPLE_WIDTH`.
- `SAMPLE_WIDTH`, 16: signed sample width. Each beat holds `N = DATA_WIDTH/SAMPLE_WIDTH` samples; sample 0 is in the LSBs and is the oldest.
- `CNT_WIDTH`, 32: width of the beat counter and of `cap_beats`.

Ports:
- `rf_clk`  in  1  sole clock.
- `rf_rst`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`  in  DATA_WIDTH  ADC beat.
- `s_axis_tvalid`  in  1  ADC beat valid.
- `s_axis_tready`  out  1  constant 1. The ADC is never back-pressured.
- `m_axis_tdata`  out  DATA_WIDTH  captured beat to `adc_data_path`.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  high on the final beat of the capture.
- `arm`  in  1  single-cycle pulse that starts a capture.
- `abort`  in  1  single-cycle pulse that returns the block to IDLE.
- `trig_mode`  in  2  trigger source: 0 = immediate, 1 = level rising-edge, 2 = external, 3 = reserved (behaves as 0).
- `trig_level`  in  SAMPLE_WIDTH  signed threshold for mode 1.
- `ext_trig`  in  1  external trigger level, already synchronous to `rf_clk`.
- `cap_beats`  in  CNT_WIDTH  number of beats to capture. Sampled on `arm`.
- `state`  out  2  current state: 0 = IDLE, 1 = ARMED, 2 = CAPTURE, 3 = DONE.
- `done`  out  1  high while `state` is DONE.
- `overflow`  out  1  sticky flag: a beat was dropped during CAPTURE.
- `beat_cnt`  out  CNT_WIDTH  number of beats loaded into the output register in the current capture.

## Operation
State machine:
- **IDLE**
  - `arm` with `cap_beats != 0`: latch `cap_beats`, `trig_mode` and `trig_level`, clear `overflow` and `beat_cnt`, go to ARMED.
  - `arm` with `cap_beats == 0`: ignored; stay in IDLE.
- **ARMED**
  - A trigger fires on a cycle with `s_axis_tvalid` = 1 and the trigger condition true.
  - The triggering beat is captured as beat 0: it is loaded into the output register, `beat_cnt` becomes 1, and the state goes to CAPTURE.
  - If `cap_beats` = 1, the state skips CAPTURE: the beat carries tlast and the state goes to DONE once that beat is handed off.
- **CAPTURE**
  - Each valid input beat is loaded if the output register is free, i.e. `!m_axis_tvalid || m_axis_tready`, and `beat_cnt` increments.
  - If the register is not free, the beat is dropped, `overflow` is set, and the beat is not counted.
  - The beat loaded when `beat_cnt` = `cap_beats`-1 carries tlast.
  - After the tlast beat is loaded, no further input is accepted. The state goes to DONE on the cycle the tlast beat completes its handshake (`m_axis_tvalid` & `m_axis_tready` & `m_axis_tlast`).
- **DONE**
  - Holds until `arm` (behaves as in IDLE) or `abort` (goes to IDLE).

Trigger conditions, evaluated combinationally on the current input beat:
- Mode 0: always true.
- Mode 2: `ext_trig` = 1 on the same cycle as the valid beat.
- Mode 1: true if any sample i in 0..N-1 satisfies prev < `trig_level` <= cur, where:
  - cur is sample i;
  - prev is sample i-1 of the same beat; for i = 0, prev is sample N-1 of the previous valid beat.
  - The previous-sample register updates on every valid beat in every state and resets to the most negative value.
  - All comparisons are signed.

Other rules:
- `arm` received in ARMED or CAPTURE is ignored.
- `abort` in any state, including mid-capture: go to IDLE next cycle, clear `m_axis_tvalid` and `m_axis_tlast`, and drop any pending beat. `overflow` and `beat_cnt` keep their values.
- This abort is the only permitted AXI-stream protocol break. Software must pulse `adc_reset` in `adc_data_path` afterwards.
- Simultaneous `arm` and `abort`: `abort` wins.
- `m_axis_tdata` must hold stable while `m_axis_tvalid` is high and `m_axis_tready` is low.

## Timing
- All outputs are registered. `s_axis_tready` is a constant 1.
- Reset values: `state` = 0, `done` = 0, `overflow` = 0, `beat_cnt` = 0, `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0.
- Latency: an input beat accepted at edge k appears on `m_axis` with `m_axis_tvalid` = 1 after edge k, i.e. one cycle.
- With `m_axis_tready` held at 1 and continuous input, throughput is one beat per cycle and no beats are dropped.
- `done` rises one cycle after the tlast handshake.
- `beat_cnt` wraps modulo 2^CNT_WIDTH. It cannot wrap in practice because `cap_beats` < 2^CNT_WIDTH.

## Test plan
1. **Immediate capture.** Mode 0, `cap_beats` = 10, `m_axis_tready` = 1, continuous incrementing beats starting at 0x…05, `arm` pulse. Required: exactly 10 consecutive beats out, starting with the first beat after `arm`; tlast only on beat 9; `done` = 1; `beat_cnt` = 10; `overflow` = 0.
2. **Level trigger across a beat boundary.** Mode 1, `trig_level` = 0x0100. Beat A has sample 7 = 0x00FF; beat B has sample 0 = 0x0100; all earlier samples are below the level. Required: beat B is the first output beat. Repeat with the crossing placed at sample 3 inside a single beat: that beat is the first output.
3. **Backpressure / overflow.** Mode 0, `cap_beats` = 8, `m_axis_tready` toggling 1,0. Required: `overflow` = 1; exactly 8 beats output; tlast on the 8th; output data stable while stalled.
4. **Abort mid-capture.** `cap_beats` = 100, `abort` after 20 beats. Required: `state` = IDLE next cycle; `m_axis_tvalid` = 0; `beat_cnt` = 20. A subsequent `arm` then captures a full 100 beats.
5. **Edge cases.** `arm` with `cap_beats` = 0 → stays IDLE. `arm` while in CAPTURE → ignored. Mode 2 with `ext_trig` pulsing on a cycle with `s_axis_tvalid` = 0 → no trigger. Async `rf_rst` asserted mid-capture → all outputs return to reset values immediately.

Source files
------------

// File: rtl/adc_trig_gate.sv
// Trigger and capture-length gate for one RF-ADC stream lane.
// Waits for a trigger after arm, then forwards exactly cap_beats beats with tlast on the final one.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no capture in progress, input samples are discarded
// ARMED    | waiting for the trigger condition on a valid input beat
// CAPTURE  | forwarding beats until the tlast beat has been handed off
// DONE     | capture complete, waiting for the next arm or an abort
module adc_trig_gate #(
    parameter int DATA_WIDTH   = 128,
    parameter int SAMPLE_WIDTH = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    rf_clk,
    input  logic                    rf_rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [1:0]              trig_mode,
    input  logic [SAMPLE_WIDTH-1:0] trig_level,
    input  logic                    ext_trig,
    input  logic [CNT_WIDTH-1:0]    cap_beats,
    output logic [1:0]              state,
    output logic                    done,
    output logic                    overflow,
    output logic [CNT_WIDTH-1:0]    beat_cnt
);

    localparam int N = DATA_WIDTH / SAMPLE_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                          r_state;
    logic [CNT_WIDTH-1:0]            r_cap_beats;
    logic [1:0]                      r_mode;
    logic signed [SAMPLE_WIDTH-1:0]  r_level;
    logic signed [SAMPLE_WIDTH-1:0]  r_prev;
    logic [DATA_WIDTH-1:0]           r_tdata;
    logic                            r_tvalid;
    logic                            r_tlast;
    logic                            r_done;
    logic                            r_overflow;
    logic [CNT_WIDTH-1:0]            r_beat_cnt;

    // w_samp[0] is the newest sample of the previous beat, w_samp[i+1] is sample i of this beat
    logic signed [SAMPLE_WIDTH-1:0]  w_samp [0:N];
    logic                            w_level_hit;
    logic                            w_trig;
    logic                            w_free;
    logic                            w_last_hs;

    always_comb begin
        w_samp[0] = r_prev;
        for (int i = 0; i < N; i++) begin
            w_samp[i+1] = s_axis_tdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
    end

    always_comb begin
        w_level_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((w_samp[i] < r_level) && (r_level <= w_samp[i+1])) begin
                w_level_hit = 1'b1;
            end
        end
    end

    always_comb begin
        case (r_mode)
            2'd1:    w_trig = w_level_hit;
            2'd2:    w_trig = ext_trig;
            default: w_trig = 1'b1;
        endcase
    end

    assign w_free    = !r_tvalid || m_axis_tready;
    assign w_last_hs = r_tvalid && r_tlast && m_axis_tready;

    always_ff @(posedge rf_clk or posedge rf_rst) begin
        if (rf_rst) begin
            r_state     <= ST_IDLE;
            r_cap_beats <= '0;
            r_mode      <= 2'd0;
            r_level     <= '0;
            r_prev      <= {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_beat_cnt  <= '0;
        end else begin
            if (s_axis_tvalid) begin
                r_prev <= w_samp[N];
            end
            // Drain the output register; a load below overrides this
            if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end

            if (abort) begin
                r_state  <= ST_IDLE;
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (arm && (cap_beats != '0)) begin
                            r_cap_beats <= cap_beats;
                            r_mode      <= trig_mode;
                            r_level     <= trig_level;
                            r_overflow  <= 1'b0;
                            r_beat_cnt  <= '0;
                            r_done      <= 1'b0;
                            r_state     <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        // A single-beat capture waits here for its tlast handoff
                        if (r_tlast) begin
                            if (w_last_hs) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end else if (s_axis_tvalid && w_trig) begin
                            r_tdata    <= s_axis_tdata;
                            r_tvalid   <= 1'b1;
                            r_beat_cnt <= CNT_WIDTH'(1);
                            if (r_cap_beats == CNT_WIDTH'(1)) begin
                                r_tlast <= 1'b1;
                            end else begin
                                r_state <= ST_CAPTURE;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (r_tlast) begin
                            if (w_last_hs) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end else if (s_axis_tvalid) begin
                            if (w_free) begin
                                r_tdata    <= s_axis_tdata;
                                r_tvalid   <= 1'b1;
                                r_tlast    <= (r_beat_cnt == (r_cap_beats - CNT_WIDTH'(1)));
                                r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign s_axis_tready = 1'b1;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign state         = r_state;
    assign done          = r_done;
    assign overflow      = r_overflow;
    assign beat_cnt      = r_beat_cnt;

endmodule

// File: tb/tb_adc_trig_gate.sv
// Bench for adc_trig_gate: expected output beats are queued as stimulus is driven
// and popped by a monitor on each output handshake.
module tb_adc_trig_gate;

    localparam int DW = 128;
    localparam int SW = 16;
    localparam int CW = 32;
    localparam int N  = DW / SW;

    logic          rf_clk = 1'b0;
    logic          rf_rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          arm;
    logic          abort;
    logic [1:0]    trig_mode;
    logic [SW-1:0] trig_level;
    logic          ext_trig;
    logic [CW-1:0] cap_beats;
    logic [1:0]    state;
    logic          done;
    logic          overflow;
    logic [CW-1:0] beat_cnt;

    adc_trig_gate #(.DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .rf_clk(rf_clk), .rf_rst(rf_rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_level(trig_level),
        .ext_trig(ext_trig), .cap_beats(cap_beats),
        .state(state), .done(done), .overflow(overflow), .beat_cnt(beat_cnt)
    );

    always #5 rf_clk = ~rf_clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            errors = 0;
    int            checks = 0;
    logic          stall_pending = 1'b0;
    logic [DW-1:0] stall_data;

    always @(negedge rf_clk) begin
        if (rf_rst) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending && m_axis_tvalid) begin
                checks++;
                if (m_axis_tdata !== stall_data) begin
                    errors++;
                    $display("FAIL stall_stable: got %h want %h", m_axis_tdata, stall_data);
                end
            end
            stall_pending = m_axis_tvalid && !m_axis_tready;
            stall_data    = m_axis_tdata;
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data %h last %b, want no beat", m_axis_tdata, m_axis_tlast);
                end else begin
                    mon_e = sb.pop_front();
                    if (m_axis_tdata !== mon_e.data || m_axis_tlast !== mon_e.last) begin
                        errors++;
                        $display("FAIL out_beat: got data %h last %b, want data %h last %b",
                                 m_axis_tdata, m_axis_tlast, mon_e.data, mon_e.last);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge rf_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        tick();
    endtask

    task automatic push(input logic [DW-1:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        sb.push_back(e);
    endtask

    function automatic logic [DW-1:0] rep(input logic [SW-1:0] s);
        return {N{s}};
    endfunction

    task automatic check_done(input string name, input int n);
        checks++;
        if (state !== 2'd3 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: got state %0d done %b, want state 3 done 1", name, state, done);
        end
        checks++;
        if (beat_cnt !== CW'(n)) begin
            errors++;
            $display("FAIL %s_beat_cnt: got %0d want %0d", name, beat_cnt, n);
        end
    endtask

    // Mode 0 capture of n beats with tready held high; the beat seen with arm is not captured
    task automatic run_immediate(input string name, input int n, input logic [DW-1:0] base);
        trig_mode = 2'd0;
        cap_beats = CW'(n);
        m_axis_tready = 1'b1;
        arm = 1'b1;
        drive(1'b1, base);
        arm = 1'b0;
        for (int k = 1; k <= n; k++) begin
            push(base + DW'(k), k == n);
            drive(1'b1, base + DW'(k));
        end
        drive(1'b0, '0);
        check_done(name, n);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL %s_overflow: got %b want 0", name, overflow);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d pending want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rf_rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (state !== 2'd0 || done !== 1'b0 || overflow !== 1'b0 || beat_cnt !== '0) begin
            errors++;
            $display("FAIL reset_status: got state %0d done %b ovf %b cnt %0d, want 0 0 0 0",
                     state, done, overflow, beat_cnt);
        end
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0 || s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_stream: got valid %b last %b data %h ready %b, want 0 0 0 1",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready);
        end
        rf_rst = 1'b0;
        tick();
    endtask

    task automatic test_immediate();
        run_immediate("imm", 10, 128'h05);
    endtask

    task automatic test_level_trigger();
        logic [DW-1:0] ba, bb, bc, bd, be;
        trig_mode  = 2'd1;
        trig_level = 16'h0100;
        cap_beats  = 2;
        drive(1'b1, rep(16'h0000));
        arm = 1'b1;
        drive(1'b0, '0);
        arm = 1'b0;
        ba = {16'h00FF, 112'h0};
        bb = rep(16'h0100);
        bc = rep(16'h0123);
        drive(1'b1, ba);
        push(bb, 1'b0);
        drive(1'b1, bb);
        push(bc, 1'b1);
        drive(1'b1, bc);
        drive(1'b0, '0);
        check_done("lvl_boundary", 2);

        // Crossing inside one beat; the preceding beat holds negative samples that must not trigger
        cap_beats = 1;
        drive(1'b1, rep(16'h0000));
        arm = 1'b1;
        drive(1'b0, '0);
        arm = 1'b0;
        bd = {{7{16'hFF00}}, 16'h0000};
        be = {{5{16'h0200}}, {3{16'h0050}}};
        drive(1'b1, bd);
        checks++;
        if (state !== 2'd1 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL lvl_signed: got state %0d valid %b, want state 1 valid 0", state, m_axis_tvalid);
        end
        push(be, 1'b1);
        drive(1'b1, be);
        drive(1'b0, '0);
        check_done("lvl_inner", 1);
    endtask

    task automatic test_overflow();
        logic          m_tv, m_ll, fin, rdy;
        int            m_cnt;
        logic [DW-1:0] d;
        trig_mode = 2'd0;
        cap_beats = 8;
        arm = 1'b1;
        drive(1'b0, '0);
        arm = 1'b0;
        m_tv = 1'b0;
        m_ll = 1'b0;
        fin  = 1'b0;
        m_cnt = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            rdy = (c % 2 == 0);
            m_axis_tready = rdy;
            d = 128'hA000 + DW'(c);
            if (!m_ll) begin
                if (!m_tv || rdy) begin
                    push(d, m_cnt == 7);
                    m_cnt++;
                    m_tv = 1'b1;
                    if (m_cnt == 8) m_ll = 1'b1;
                end
            end else if (rdy) begin
                fin = 1'b1;
            end
            drive(1'b1, d);
        end
        m_axis_tready = 1'b1;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL ovf_timeout: got no tlast handoff within 40 cycles, want one");
        end
        check_done("ovf", 8);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b want 1", overflow);
        end
        drive(1'b0, '0);
    endtask

    task automatic test_abort();
        trig_mode = 2'd0;
        cap_beats = 100;
        m_axis_tready = 1'b1;
        arm = 1'b1;
        drive(1'b0, '0);
        arm = 1'b0;
        for (int k = 0; k < 20; k++) begin
            push(128'hB000 + DW'(k), 1'b0);
            drive(1'b1, 128'hB000 + DW'(k));
        end
        abort = 1'b1;
        drive(1'b1, 128'hBFFF);
        abort = 1'b0;
        checks++;
        if (state !== 2'd0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got state %0d valid %b last %b, want 0 0 0", state, m_axis_tvalid, m_axis_tlast);
        end
        checks++;
        if (beat_cnt !== CW'(20)) begin
            errors++;
            $display("FAIL abort_beat_cnt: got %0d want 20", beat_cnt);
        end
        drive(1'b1, 128'hBEEF);
        run_immediate("abort_rearm", 100, 128'hC000);
    endtask

    task automatic test_edge_cases();
        abort = 1'b1;
        drive(1'b0, '0);
        abort = 1'b0;
        cap_beats = 0;
        arm = 1'b1;
        drive(1'b1, 128'h1);
        arm = 1'b0;
        drive(1'b1, 128'h2);
        checks++;
        if (state !== 2'd0 || done !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL zero_cap: got state %0d done %b valid %b, want 0 0 0", state, done, m_axis_tvalid);
        end

        // arm during CAPTURE with a different length must not restart or relatch
        trig_mode = 2'd0;
        cap_beats = 5;
        arm = 1'b1;
        drive(1'b0, '0);
        arm = 1'b0;
        push(128'hD000, 1'b0);
        drive(1'b1, 128'hD000);
        cap_beats = 3;
        arm = 1'b1;
        push(128'hD001, 1'b0);
        drive(1'b1, 128'hD001);
        arm = 1'b0;
        for (int k = 2; k < 5; k++) begin
            push(128'hD000 + DW'(k), k == 4);
            drive(1'b1, 128'hD000 + DW'(k));
        end
        drive(1'b0, '0);
        check_done("arm_in_cap", 5);

        // External trigger only counts on a valid beat
        trig_mode = 2'd2;
        cap_beats = 2;
        ext_trig  = 1'b0;
        arm = 1'b1;
        drive(1'b0, '0);
        arm = 1'b0;
        drive(1'b1, 128'hE000);
        ext_trig = 1'b1;
        drive(1'b0, 128'hE001);
        ext_trig = 1'b0;
        drive(1'b1, 128'hE002);
        checks++;
        if (state !== 2'd1 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL ext_no_valid: got state %0d valid %b, want state 1 valid 0", state, m_axis_tvalid);
        end
        ext_trig = 1'b1;
        push(128'hE003, 1'b0);
        drive(1'b1, 128'hE003);
        ext_trig = 1'b0;
        push(128'hE004, 1'b1);
        drive(1'b1, 128'hE004);
        drive(1'b0, '0);
        check_done("ext", 2);

        // Asynchronous reset in the middle of a capture
        trig_mode = 2'd0;
        cap_beats = 50;
        arm = 1'b1;
        drive(1'b0, '0);
        arm = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push(128'hF000 + DW'(k), 1'b0);
            drive(1'b1, 128'hF000 + DW'(k));
        end
        #2;
        rf_rst = 1'b1;
        #1;
        sb.delete();
        checks++;
        if (state !== 2'd0 || done !== 1'b0 || overflow !== 1'b0 || beat_cnt !== '0 ||
            m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0) begin
            errors++;
            $display("FAIL async_rst: got state %0d done %b ovf %b cnt %0d valid %b last %b data %h, want all 0",
                     state, done, overflow, beat_cnt, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        tick();
        rf_rst = 1'b0;
        tick();
        run_immediate("post_rst", 3, 128'h7700);
    endtask

    initial begin
        rf_rst        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        arm           = 1'b0;
        abort         = 1'b0;
        trig_mode     = 2'd0;
        trig_level    = '0;
        ext_trig      = 1'b0;
        cap_beats     = '0;

        test_reset();
        test_immediate();
        test_level_trigger();
        test_overflow();
        test_abort();
        test_edge_cases();

        repeat (2) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d pending beats want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
